// File: rtl/karlsen_pkg.sv
// Shared constants, state encoding and helpers for the Karlsen CV conditioner.
// The exponential table spans 8 octaves in 17 half-octave points.
package karlsen_pkg;

  localparam int FRAC_BITS = 11;
  localparam int IDX_BITS  = 4;

  // t[k] = round(32767 * 2^((k-16)/2))
  localparam logic [15:0] G_TABLE [17] = '{
    16'd128,   16'd181,   16'd256,   16'd362,
    16'd512,   16'd724,   16'd1024,  16'd1448,
    16'd2048,  16'd2896,  16'd4096,  16'd5792,
    16'd8192,  16'd11585, 16'd16384, 16'd23170,
    16'd32767
  };

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SLEW    = 3'd2,
    LUT     = 3'd3,
    INTERP  = 3'd4,
    COMMIT  = 3'd5
  } cvc_state_t;

  function automatic int sat(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/exp_lut_interp.sv
// Octave-linear control mapping: table fetch at the top index bits and linear
// interpolation on the fractional bits. Purely combinational.
module exp_lut_interp
  import karlsen_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-2:0] cut,
  output logic [W-1:0] gi
);

  logic [IDX_BITS:0]    idx;
  logic [FRAC_BITS-1:0] frac;
  logic [15:0]          t_lo;
  logic [15:0]          t_hi;

  assign idx  = {1'b0, cut[W-2 -: IDX_BITS]};
  assign frac = cut[FRAC_BITS-1:0];
  assign t_lo = G_TABLE[idx];
  assign t_hi = G_TABLE[idx + 1'b1];

  // Table is monotonic, so the slope term is never negative.
  assign gi = W'(int'(t_lo) + (((int'(t_hi) - int'(t_lo)) * int'(frac)) >>> FRAC_BITS));

endmodule

// File: rtl/karlsen_cv_conditioner.sv
// Per-sample cutoff/resonance conditioning for the Karlsen ladder stage.
// g and resonance update together on one edge, with a re-timed sample strobe.
module karlsen_cv_conditioner
  import karlsen_pkg::*;
#(
  parameter int W         = 16,
  parameter int SLEW_STEP = 1024,
  parameter int RES_SHIFT = 2,
  parameter int RES_MAX   = 16383,
  parameter int LAT       = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_clk,
  input  logic [W-1:0] cutoff_cv,
  input  logic [W-1:0] resonance_cv,
  output logic [W-1:0] g,
  output logic [W-1:0] resonance,
  output logic         sample_clk_out,
  output logic [2:0]   fsm_state
);

  localparam int CUT_MAX = 2 ** (W - 1) - 1;

  cvc_state_t          state;
  logic                prev;
  logic                toggle;
  logic [2:0]          age;
  logic signed [W-1:0] cap_cut;
  logic signed [W-1:0] cap_res;
  logic signed [W:0]   d;
  logic signed [W-1:0] res_tgt;
  logic signed [W-1:0] cut_s;
  logic signed [W-1:0] res_s;
  logic signed [W-1:0] cut_n;
  logic signed [W-1:0] res_n;
  logic [W-1:0]        gi;
  logic [W-1:0]        gi_r;

  assign toggle    = (sample_clk != prev);
  assign fsm_state = state;

  exp_lut_interp #(.W(W)) u_lut (
    .cut (cut_n[W-2:0]),
    .gi  (gi)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      prev           <= 1'b0;
      age            <= 3'd0;
      cap_cut        <= '0;
      cap_res        <= '0;
      d              <= '0;
      res_tgt        <= '0;
      cut_s          <= '0;
      res_s          <= '0;
      cut_n          <= '0;
      res_n          <= '0;
      gi_r           <= '0;
      g              <= '0;
      resonance      <= '0;
      sample_clk_out <= 1'b0;
    end else begin
      prev <= sample_clk;
      if (toggle) begin
        // A new sample always wins, even mid-pass: the old pass is dropped.
        state   <= CAPTURE;
        cap_cut <= cutoff_cv;
        cap_res <= resonance_cv;
        age     <= 3'd1;
      end else begin
        if (state != IDLE) age <= age + 3'd1;
        case (state)
          IDLE: begin
          end
          CAPTURE: begin
            d       <= (W+1)'(sat(sat(int'(cap_cut), 0, CUT_MAX) - int'(cut_s),
                                  -SLEW_STEP, SLEW_STEP));
            res_tgt <= W'(sat(int'(cap_res), 0, RES_MAX));
            state   <= SLEW;
          end
          SLEW: begin
            cut_n <= W'(int'(cut_s) + int'(d));
            res_n <= W'(int'(res_s) + ((int'(res_tgt) - int'(res_s)) >>> RES_SHIFT));
            state <= LUT;
          end
          LUT: begin
            // cut_n is held from here to commit, giving the table path a full cycle.
            state <= INTERP;
          end
          INTERP: begin
            gi_r  <= gi;
            state <= COMMIT;
          end
          COMMIT: begin
            assert (int'(age) == LAT);
            g              <= gi_r;
            resonance      <= res_n;
            cut_s          <= cut_n;
            res_s          <= res_n;
            sample_clk_out <= ~sample_clk_out;
            age            <= 3'd0;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_karlsen_cv_conditioner.sv
// Bench for karlsen_cv_conditioner: table vectors, hand sequences for reset and
// retrigger, then random samples against an arithmetic reference model.
module tb_karlsen_cv_conditioner;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sample_clk = 1'b0;
  logic [W-1:0] cutoff_cv = '0;
  logic [W-1:0] resonance_cv = '0;
  logic [W-1:0] g;
  logic [W-1:0] resonance;
  logic         sample_clk_out;
  logic [2:0]   fsm_state;

  always #5 clk = ~clk;

  karlsen_cv_conditioner dut (
    .clk            (clk),
    .rst            (rst),
    .sample_clk     (sample_clk),
    .cutoff_cv      (cutoff_cv),
    .resonance_cv   (resonance_cv),
    .g              (g),
    .resonance      (resonance),
    .sample_clk_out (sample_clk_out),
    .fsm_state      (fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int tab [17];
  int m_cut, m_res, m_g, m_rout, m_sco;

  typedef struct {
    int cv;
    int rv;
    int n;
    int exp_g;
    int exp_res;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 50) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int model_g(input int cut);
    int idx;
    int frac;
    idx  = cut / 2048;
    frac = cut % 2048;
    return tab[idx] + ((tab[idx + 1] - tab[idx]) * frac) / 2048;
  endfunction

  task automatic model_reset();
    m_cut = 0; m_res = 0; m_g = 0; m_rout = 0; m_sco = 0;
  endtask

  task automatic model_apply(input int cv, input int rv);
    int tgt;
    int rt;
    tgt    = clampi(cv, 0, 32767);
    m_cut  = m_cut + clampi(tgt - m_cut, -1024, 1024);
    rt     = clampi(rv, 0, 16383);
    m_res  = m_res + ((rt - m_res) >>> 2);
    m_g    = model_g(m_cut);
    m_rout = m_res;
    m_sco  = m_sco ^ 1;
  endtask

  task automatic drive_toggle(input int cv, input int rv);
    cutoff_cv    = 16'(cv);
    resonance_cv = 16'(rv);
    sample_clk   = ~sample_clk;
  endtask

  // Called right after a toggle is driven; expects the commit 5 cycles after T0.
  task automatic wait_commit(input int cv, input int rv);
    int lat;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (int'(sample_clk_out) != m_sco) begin
        lat = c - 1;
        break;
      end
      check("hold_g", int'(g), m_g);
      check("hold_res", int'(resonance), m_rout);
    end
    check("commit_latency", lat, 5);
    if (lat >= 0) begin
      model_apply(cv, rv);
      check("commit_g", int'(g), m_g);
      check("commit_res", int'(resonance), m_rout);
      check("commit_strobe", int'(sample_clk_out), m_sco);
    end
  endtask

  task automatic do_sample(input int cv, input int rv);
    @(posedge clk); #1;
    drive_toggle(cv, rv);
    wait_commit(cv, rv);
  endtask

  task automatic do_retrig(input int cv1, input int rv1, input int gap,
                           input int cv2, input int rv2);
    @(posedge clk); #1;
    drive_toggle(cv1, rv1);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      check("retrig_strobe_hold", int'(sample_clk_out), m_sco);
      check("retrig_g_hold", int'(g), m_g);
    end
    drive_toggle(cv2, rv2);
    wait_commit(cv2, rv2);
  endtask

  function automatic int rand_cv();
    case ($urandom_range(0, 5))
      0: return 32767;
      1: return -32768;
      2: return $urandom_range(0, 2048);
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 17; k++)
      tab[k] = $rtoi(32767.0 * $pow(2.0, (k - 16) / 2.0) + 0.5);

    vecs[0] = '{0,     0,     1,  128,  0};
    vecs[1] = '{1024,  8000,  1,  154,  2000};
    vecs[2] = '{1024,  8000,  1,  154,  3500};
    vecs[3] = '{1024,  8000,  1,  154,  4625};
    vecs[4] = '{16384, 30000, 15, 2048, 16224};
    vecs[5] = '{-5000, 30000, 20, 128,  16380};

    // clock/reset
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_g", int'(g), 0);
    check("reset_res", int'(resonance), 0);
    check("reset_strobe", int'(sample_clk_out), 0);
    check("reset_state", int'(fsm_state), 0);
    check("table_0", tab[0], 128);
    check("table_8", tab[8], 2048);
    check("table_16", tab[16], 32767);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // table-driven vectors
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < vecs[i].n; s++) do_sample(vecs[i].cv, vecs[i].rv);
      check($sformatf("vec%0d_g", i), int'(g), vecs[i].exp_g);
      check($sformatf("vec%0d_res", i), int'(resonance), vecs[i].exp_res);
    end

    // full-scale cutoff step: one slew step per sample, then saturation
    for (int s = 1; s <= 34; s++) begin
      do_sample(32767, 0);
      if (s == 1)  check("ramp_s1_g", int'(g), 154);
      if (s == 16) check("ramp_s16_g", int'(g), 2048);
      if (s == 32) check("ramp_s32_g", int'(g), model_g(32767));
    end
    check("ramp_hold_g", int'(g), model_g(32767));

    // retrigger two cycles after T0: single commit, single slew step
    do_retrig(16384, 5000, 2, 0, 0);
    check("retrig_g_one_step", int'(g), model_g(32767 - 1024));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("retrig_no_extra_strobe", int'(sample_clk_out), m_sco);
    end

    // asynchronous reset in the middle of a pass
    @(posedge clk); #1;
    drive_toggle(16384, 8000);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midreset_g", int'(g), 0);
    check("midreset_res", int'(resonance), 0);
    check("midreset_strobe", int'(sample_clk_out), 0);
    check("midreset_state", int'(fsm_state), 0);
    sample_clk   = 1'b0;
    cutoff_cv    = '0;
    resonance_cv = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    do_sample(16384, 8000);
    check("postreset_strobe", int'(sample_clk_out), 1);
    check("postreset_g", int'(g), 154);
    check("postreset_res", int'(resonance), 2000);

    // randomized samples and retriggers against the model
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 4) == 0)
        do_retrig(rand_cv(), rand_cv(), $urandom_range(1, 5), rand_cv(), rand_cv());
      else
        do_sample(rand_cv(), rand_cv());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
